// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/capture stage for a 4-input function: steps {a,b,c,d} through 0..15,
// samples y on the last held cycle of each vector and grades the packed table against EXPECTED.
module truth_table_sweeper #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [15:0] EXPECTED    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        y,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] captured,
  output logic        pass,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FINISH,
    DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [3:0] idx;
  logic [7:0] hold_cnt;
  logic       sample_mismatch;

  assign {a, b, c, d}    = idx;
  assign sample_mismatch = (y != EXPECTED[idx]);

  // idx only moves on a capture edge, so each vector stays stable for exactly HOLD_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      hold_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      captured       <= '0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      first_fail     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= HOLD;
            idx            <= '0;
            hold_cnt       <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            captured       <= '0;
            mismatch_count <= '0;
            first_fail     <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            captured[idx] <= y;
            if (sample_mismatch) begin
              mismatch_count <= mismatch_count + 5'd1;
              if (mismatch_count == 5'd0) begin
                first_fail <= idx;
              end
            end
            if (idx == 4'd15) begin
              state <= FINISH;
            end else begin
              idx      <= idx + 4'd1;
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        FINISH: begin
          // The last capture landed on the previous edge, so captured is complete here.
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (captured == EXPECTED);
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: five sweeper instances with different function models and golden tables,
// checked cycle by cycle against hand-derived timing and final results.
module tb_truth_table_sweeper;

  logic clk;
  logic rst;
  logic start_main;
  logic start_c;

  int checkCount;
  int passCount;

  // y = a^b^c^d, golden 6996
  logic x_a, x_b, x_c, x_d, x_busy, x_done, x_pass;
  logic [15:0] x_captured;
  logic [4:0]  x_mm;
  logic [3:0]  x_ff;
  // y = a&b&c&d, golden 8001
  logic n_a, n_b, n_c, n_d, n_busy, n_done, n_pass;
  logic [15:0] n_captured;
  logic [4:0]  n_mm;
  logic [3:0]  n_ff;
  // y = 1, golden 0000
  logic o_a, o_b, o_c, o_d, o_busy, o_done, o_pass;
  logic [15:0] o_captured;
  logic [4:0]  o_mm;
  logic [3:0]  o_ff;
  // y = d, golden 0000
  logic f_a, f_b, f_c, f_d, f_busy, f_done, f_pass;
  logic [15:0] f_captured;
  logic [4:0]  f_mm;
  logic [3:0]  f_ff;
  // y = c, golden CCCC, two-cycle hold
  logic c_a, c_b, c_c, c_d, c_busy, c_done, c_pass;
  logic [15:0] c_captured;
  logic [4:0]  c_mm;
  logic [3:0]  c_ff;

  truth_table_sweeper #(.HOLD_CYCLES(10), .EXPECTED(16'h6996)) u_xor (
    .clk(clk), .rst(rst), .start(start_main), .y(x_a ^ x_b ^ x_c ^ x_d),
    .a(x_a), .b(x_b), .c(x_c), .d(x_d), .busy(x_busy), .done(x_done),
    .captured(x_captured), .pass(x_pass), .mismatch_count(x_mm), .first_fail(x_ff));

  truth_table_sweeper #(.HOLD_CYCLES(10), .EXPECTED(16'h8001)) u_and (
    .clk(clk), .rst(rst), .start(start_main), .y(n_a & n_b & n_c & n_d),
    .a(n_a), .b(n_b), .c(n_c), .d(n_d), .busy(n_busy), .done(n_done),
    .captured(n_captured), .pass(n_pass), .mismatch_count(n_mm), .first_fail(n_ff));

  truth_table_sweeper #(.HOLD_CYCLES(10), .EXPECTED(16'h0000)) u_one (
    .clk(clk), .rst(rst), .start(start_main), .y(1'b1),
    .a(o_a), .b(o_b), .c(o_c), .d(o_d), .busy(o_busy), .done(o_done),
    .captured(o_captured), .pass(o_pass), .mismatch_count(o_mm), .first_fail(o_ff));

  truth_table_sweeper #(.HOLD_CYCLES(10), .EXPECTED(16'h0000)) u_ffx (
    .clk(clk), .rst(rst), .start(start_main), .y(f_d),
    .a(f_a), .b(f_b), .c(f_c), .d(f_d), .busy(f_busy), .done(f_done),
    .captured(f_captured), .pass(f_pass), .mismatch_count(f_mm), .first_fail(f_ff));

  truth_table_sweeper #(.HOLD_CYCLES(2), .EXPECTED(16'hCCCC)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .y(c_c),
    .a(c_a), .b(c_b), .c(c_c), .d(c_d), .busy(c_busy), .done(c_done),
    .captured(c_captured), .pass(c_pass), .mismatch_count(c_mm), .first_fail(c_ff));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Runs one sweep from the start edge T; m counts edges after T. pulseAt injects a
  // stray start into the HOLD-10 instances at that point (-1 for none).
  task automatic applyStimulus(input int pulseAt);
    int expIdx;
    int expIdxC;
    int k;
    logic [15:0] mask;
    @(negedge clk);
    start_main = 1'b1;
    start_c    = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    start_c    = 1'b0;
    for (int m = 0; m <= 165; m++) begin
      if (m > 0) @(negedge clk);
      expIdx  = (m < 160) ? m / 10 : 15;
      expIdxC = (m < 32) ? m / 2 : 15;
      k       = (m / 10 > 16) ? 16 : m / 10;
      mask    = (k == 16) ? 16'hFFFF : 16'((32'd1 << k) - 32'd1);
      checkOutput("xor_idx", 32'({x_a, x_b, x_c, x_d}), 32'(expIdx));
      checkOutput("xor_busy", 32'(x_busy), 32'(m <= 160));
      checkOutput("xor_done", 32'(x_done), 32'(m >= 161));
      checkOutput("xor_pass", 32'(x_pass), 32'(m >= 161));
      checkOutput("xor_captured", 32'(x_captured), 32'(16'h6996 & mask));
      checkOutput("c_idx", 32'({c_a, c_b, c_c, c_d}), 32'(expIdxC));
      checkOutput("c_busy", 32'(c_busy), 32'(m <= 32));
      checkOutput("c_done", 32'(c_done), 32'(m >= 33));
      if (m == 0) begin
        checkOutput("xor_mm_cleared", 32'(x_mm), 32'd0);
        checkOutput("one_captured_cleared", 32'(o_captured), 32'd0);
        checkOutput("one_mm_cleared", 32'(o_mm), 32'd0);
        checkOutput("ffx_ff_cleared", 32'(f_ff), 32'd0);
      end
      if (m == 165) begin
        checkOutput("xor_mm", 32'(x_mm), 32'd0);
        checkOutput("xor_ff", 32'(x_ff), 32'd0);
        checkOutput("and_captured", 32'(n_captured), 32'h8000);
        checkOutput("and_pass", 32'(n_pass), 32'd0);
        checkOutput("and_mm", 32'(n_mm), 32'd1);
        checkOutput("and_ff", 32'(n_ff), 32'd0);
        checkOutput("one_captured", 32'(o_captured), 32'hFFFF);
        checkOutput("one_pass", 32'(o_pass), 32'd0);
        checkOutput("one_mm", 32'(o_mm), 32'd16);
        checkOutput("one_ff", 32'(o_ff), 32'd0);
        checkOutput("ffx_captured", 32'(f_captured), 32'hAAAA);
        checkOutput("ffx_mm", 32'(f_mm), 32'd8);
        checkOutput("ffx_ff", 32'(f_ff), 32'd1);
        checkOutput("ffx_done", 32'(f_done), 32'd1);
        checkOutput("c_captured", 32'(c_captured), 32'hCCCC);
        checkOutput("c_pass", 32'(c_pass), 32'd1);
        checkOutput("c_mm", 32'(c_mm), 32'd0);
      end
      start_main = (m == pulseAt);
    end
    start_main = 1'b0;
  endtask

  task automatic checkMainCleared(input string tag);
    checkOutput({tag, "_idx"}, 32'({x_a, x_b, x_c, x_d}), 32'd0);
    checkOutput({tag, "_busy"}, 32'(x_busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(x_done), 32'd0);
    checkOutput({tag, "_captured"}, 32'(x_captured), 32'd0);
    checkOutput({tag, "_pass"}, 32'(x_pass), 32'd0);
    checkOutput({tag, "_mm"}, 32'(x_mm), 32'd0);
    checkOutput({tag, "_ff"}, 32'(x_ff), 32'd0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    start_main = 1'b0;
    start_c    = 1'b0;
    repeat (3) @(negedge clk);
    checkMainCleared("reset");
    rst = 1'b0;

    // rst and start together: rst must win and the sweeper stays idle.
    @(negedge clk);
    rst        = 1'b1;
    start_main = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    start_main = 1'b0;
    checkOutput("rst_over_start_busy", 32'(x_busy), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst_over_start_idle", 32'(x_busy), 32'd0);

    applyStimulus(-1);
    // Second sweep starts from DONE and carries a stray start at idx=3.
    applyStimulus(35);

    // Abort a sweep at idx=7.
    @(negedge clk);
    start_main = 1'b1;
    start_c    = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    start_c    = 1'b0;
    repeat (75) @(negedge clk);
    checkOutput("pre_rst_idx", 32'({x_a, x_b, x_c, x_d}), 32'd7);
    checkOutput("pre_rst_ffx_captured", 32'(f_captured), 32'h002A);
    checkOutput("pre_rst_ffx_mm", 32'(f_mm), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkMainCleared("abort");
    checkOutput("abort_ffx_captured", 32'(f_captured), 32'd0);
    checkOutput("abort_ffx_mm", 32'(f_mm), 32'd0);
    checkOutput("abort_ffx_ff", 32'(f_ff), 32'd0);
    checkOutput("abort_c_done", 32'(c_done), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("abort_idle_busy", 32'(x_busy), 32'd0);
    checkOutput("abort_idle_idx", 32'({x_a, x_b, x_c, x_d}), 32'd0);

    applyStimulus(-1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
